// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Package  : cpu_types_pkg
// Brief    : Shared RAM handshake and arbiter state types for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  localparam int c_word_w_default  = 32;
  localparam int c_timeout_default = 15;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DACC  = 2'd1,
    IACC  = 2'd2,
    FAULT = 2'd3
  } arb_state_t;

  // Counter width able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Interface : mem_arbiter_if
// Brief     : Fetch, data and RAM ports of mem_arbiter. master = requester/RAM
//             side, slave = arbiter. MEM_ARB_PERF_EN adds icnt/dcnt.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = c_word_w_default
);

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic [WORD_W-1:0] iload;
  logic              ihit;

  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic [WORD_W-1:0] dload;
  logic              dhit;
  logic              ldst;

  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  logic              err;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       icnt;
  logic [31:0]       dcnt;
`endif

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ldst,
    output ramREN, ramWEN, ramaddr, ramstore, err
`ifdef MEM_ARB_PERF_EN
    , output icnt, dcnt
`endif
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ldst,
    input  ramREN, ramWEN, ramaddr, ramstore, err
`ifdef MEM_ARB_PERF_EN
    , input icnt, dcnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-port RAM arbiter between instruction fetch and data access,
//            data first, with per-access timeout and sticky fault state.
//            Optional MEM_ARB_PERF_EN builds icnt/dcnt hit counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W  = c_word_w_default,
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam int              CNT_W         = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] c_timeout_cnt = CNT_W'(TIMEOUT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic              w_dreq;
  logic              w_access;
  logic              w_error;
  logic              w_grant_req;
  logic [CNT_W-1:0]  w_wait_inc;

  logic              w_ram_ren;
  logic              w_ram_wen;
  logic [WORD_W-1:0] w_ram_addr;
  logic [WORD_W-1:0] w_ram_store;
  logic              w_ihit;
  logic              w_dhit;
  logic              w_fault;

  assign w_dreq      = bus.dREN | bus.dWEN;
  assign w_access    = (bus.ramstate == ACCESS);
  assign w_error     = (bus.ramstate == ERROR);
  assign w_grant_req = ((state_q == DACC) & w_dreq) | ((state_q == IACC) & bus.iREN);
  assign w_wait_inc  = wait_q + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (w_dreq)        state_d = DACC;
        else if (bus.iREN) state_d = IACC;
      end
      DACC, IACC: begin
        // A RAM error is reported even if the requester has just let go.
        if (w_error) begin
          state_d = FAULT;
        end else if (!w_grant_req || w_access) begin
          state_d = IDLE;
          wait_d  = '0;
        end else begin
          wait_d = w_wait_inc;
          if (w_wait_inc >= c_timeout_cnt) state_d = FAULT;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_ram_ren   = 1'b0;
    w_ram_wen   = 1'b0;
    w_ram_addr  = '0;
    w_ram_store = '0;
    w_ihit      = 1'b0;
    w_dhit      = 1'b0;
    w_fault     = 1'b0;
    case (state_q)
      DACC: begin
        w_ram_addr  = bus.daddr;
        w_ram_store = bus.dstore;
        w_ram_wen   = bus.dWEN;
        w_ram_ren   = bus.dREN & ~bus.dWEN;
        w_dhit      = w_dreq & w_access;
      end
      IACC: begin
        w_ram_addr = bus.iaddr;
        w_ram_ren  = 1'b1;
        w_ihit     = bus.iREN & w_access;
      end
      FAULT:   w_fault = 1'b1;
      default: ;
    endcase
  end

  assign bus.ramREN   = w_ram_ren;
  assign bus.ramWEN   = w_ram_wen;
  assign bus.ramaddr  = w_ram_addr;
  assign bus.ramstore = w_ram_store;
  assign bus.ihit     = w_ihit;
  assign bus.dhit     = w_dhit;
  assign bus.iload    = w_ihit ? bus.ramload : '0;
  assign bus.dload    = w_dhit ? bus.ramload : '0;
  assign bus.err      = w_fault;
  assign bus.ldst     = w_dreq & ~w_dhit;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] icnt_q, icnt_d;
  logic [31:0] dcnt_q, dcnt_d;

  always_comb begin
    icnt_d = icnt_q + {31'd0, w_ihit};
    dcnt_d = dcnt_q + {31'd0, w_dhit};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      icnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign bus.icnt = icnt_q;
  assign bus.dcnt = dcnt_q;
`else
  // Hit counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data and address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum wait cycles per RAM access before error.
REQ-003 SHALL have port CLK  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RST  in  1  reset; synchronous and active-high.
REQ-005 SHALL have ports iREN in 1 fetch request; iaddr in WORD_W fetch address; iload out WORD_W fetched word; ihit out 1 fetch complete.
REQ-006 SHALL have ports dREN in 1 data read request; dWEN in 1 data write request; daddr in WORD_W; dstore in WORD_W; dload out WORD_W; dhit out 1 data access complete.
REQ-007 SHALL have port ldst  out  1  data access outstanding; consumed by the hazard unit.
REQ-008 SHALL have ports ramREN out 1; ramWEN out 1; ramaddr out WORD_W; ramstore out WORD_W; ramload in WORD_W; ramstate in 2 (ramstate_t: FREE, BUSY, ACCESS, ERROR).
REQ-009 SHALL have port err  out  1  sticky fault flag (RAM ERROR or timeout).

Function
REQ-010 SHALL implement FSM states IDLE, DACC, IACC, FAULT.
REQ-011 IDLE: dREN|dWEN -> DACC; else iREN -> IACC; else stay IDLE; data priority on simultaneous requests.
REQ-012 DACC drives ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN; write wins when both set.
REQ-013 IACC drives ramaddr=iaddr, ramREN=1, ramWEN=0.
REQ-014 In IDLE and FAULT, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-015 On ramstate==ACCESS in DACC/IACC: pulse dhit/ihit for exactly one cycle (combinational, same cycle), dload/iload=ramload that cycle, next state IDLE.
REQ-016 No preemption: a data request arriving during IACC waits until the fetch completes.
REQ-017 If the active request drops before ACCESS: abort to IDLE next cycle, no hit pulse, wait counter cleared.
REQ-018 Wait counter clears on entering DACC/IACC, increments each non-ACCESS cycle; reaching TIMEOUT -> FAULT.
REQ-019 ramstate==ERROR in DACC/IACC -> FAULT next cycle, no hit.
REQ-020 FAULT: err=1, no hits, stays until RST.
REQ-021 ldst = (dREN|dWEN) & ~dhit, in every state.
REQ-022 Minimum one IDLE cycle between consecutive grants; back-to-back hits impossible.

Reset
REQ-023 RST: state IDLE, counter 0, err 0; ihit=dhit=0, iload=dload=0, RAM outputs 0 the cycle after RST sampled high.
REQ-024 RST mid-access SHALL abandon the access with no hit pulse.

Configuration
REQ-025 With MEM_ARB_PERF_EN defined: ports icnt, dcnt (out, 32) count ihit and dhit pulses, wrap at 2^32, cleared by RST.
REQ-026 Without MEM_ARB_PERF_EN: ports and counters absent; all other behaviour identical.

Structure
REQ-027 ramstate_t and the FSM state enum SHALL live in cpu_types_pkg; TIMEOUT default as a package constant.
REQ-028 Single module; the wait counter SHALL NOT be a separate sub-module.

Verification
REQ-029 iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF -> ihit one cycle, iload=0xDEADBEEF, ldst=0.
REQ-030 iREN=dREN=1 same cycle -> DACC granted first, dhit, one IDLE cycle, then IACC, ihit.
REQ-031 dWEN=1, daddr=0x100, dstore=0x1234 -> ramWEN=1, ramREN=0, ramaddr=0x100, ramstore=0x1234; ldst=1 until dhit.
REQ-032 ramstate held BUSY 15 cycles in IACC -> FAULT, err=1, no ihit; RST -> err=0, IDLE.
REQ-033 dREN dropped after 1 BUSY cycle -> IDLE, no dhit; RST asserted during IACC -> no ihit, all outputs 0.
REQ-034 MEM_ARB_PERF_EN: 3 fetches + 2 loads -> icnt=3, dcnt=2.
